// File: rtl/mod5_sequence_monitor.sv
// mod5_sequence_monitor
//
// Sequence checker for a 3-bit modulo-5 counter. The block samples the counter's
// value on every clock edge and checks that it follows 0->1->2->3->4->0.
// - Each accepted 4->0 wrap produces a one-cycle Carry pulse and increments
//   the Wraps count.
// - Any illegal value, or any skipped step, latches a sticky fault. The value
//   seen and the value expected at the first fault are captured.
//
// Parameters:
//   WRAP_W       width of the wrap counter
//   AUTO_RESYNC  0: stay in FAULT until rst; 1: return to SYNC one cycle later
//
// Optional feature macro:
//   MOD5_MON_ERRCNT_EN  adds the ErrCnt[7:0] port, a saturating fault-event counter
//
// Ports:
//   clk     clock, shared with the upstream counter
//   rst     asynchronous active-high reset
//   In      count value from the upstream counter
//   Carry   one-cycle pulse per accepted wrap
//   Wraps   accepted wraps, modulo 2^WRAP_W
//   State   00 SYNC, 01 TRACK, 10 FAULT
//   Err     sticky fault flag
//   ErrVal  In sampled at the first fault
//   ErrExp  expected value at the first fault
//   ErrCnt  fault events, saturating at 255 (MOD5_MON_ERRCNT_EN only)

module mod5_sequence_monitor #(
    parameter int unsigned WRAP_W      = 8,
    parameter bit          AUTO_RESYNC = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        In,
    output logic              Carry,
    output logic [WRAP_W-1:0] Wraps,
    output logic [1:0]        State,
    output logic              Err,
    output logic [2:0]        ErrVal,
    output logic [2:0]        ErrExp
`ifdef MOD5_MON_ERRCNT_EN
    ,
    output logic [7:0]        ErrCnt
`endif
);

    typedef enum logic [1:0] {
        StSync  = 2'b00,
        StTrack = 2'b01,
        StFault = 2'b10
    } state_t;

    state_t     state_q;
    logic [2:0] exp_q;    // next expected value, never 5..7

    logic       fault;
    logic [2:0] cap_exp;  // expected value to record if this edge faults

    assign State = state_q;

    // In SYNC, an out-of-range value faults. Such a value can never also be the
    // 0 that enters TRACK, so fault priority is implicit.
    always_comb begin
        fault   = 1'b0;
        cap_exp = 3'd0;
        unique case (state_q)
            StSync: begin
                fault = (In > 3'd4);
            end
            StTrack: begin
                fault   = (In != exp_q);
                cap_exp = exp_q;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StSync;
            exp_q   <= 3'd0;
            Carry   <= 1'b0;
            Wraps   <= '0;
            Err     <= 1'b0;
            ErrVal  <= 3'd0;
            ErrExp  <= 3'd0;
`ifdef MOD5_MON_ERRCNT_EN
            ErrCnt  <= 8'd0;
`endif
        end else begin
            Carry <= 1'b0;
            if (fault) begin
                state_q <= StFault;
                exp_q   <= 3'd0;
                Err     <= 1'b1;
                // Only the first fault is captured.
                if (!Err) begin
                    ErrVal <= In;
                    ErrExp <= cap_exp;
                end
`ifdef MOD5_MON_ERRCNT_EN
                if (ErrCnt != 8'hFF) begin
                    ErrCnt <= ErrCnt + 8'd1;
                end
`endif
            end else begin
                unique case (state_q)
                    StSync: begin
                        if (In == 3'd0) begin
                            state_q <= StTrack;
                            exp_q   <= 3'd1;
                        end
                    end
                    StTrack: begin
                        if (In == 3'd4) begin
                            exp_q <= 3'd0;
                            Carry <= 1'b1;
                            Wraps <= Wraps + WRAP_W'(1);
                        end else begin
                            exp_q <= In + 3'd1;
                        end
                    end
                    StFault: begin
                        // In is ignored here; Wraps and the capture are frozen.
                        if (AUTO_RESYNC) begin
                            state_q <= StSync;
                        end
                    end
                    default: begin
                        state_q <= StSync;
                        exp_q   <= 3'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mod5_sequence_monitor.sv
module tb_mod5_sequence_monitor;

    logic       clk;
    logic       rst;
    logic [2:0] in0, in1, in2;

    logic       carry0, carry1, carry2;
    logic [7:0] wraps0, wraps1;
    logic [2:0] wraps2;
    logic [1:0] st0, st1, st2;
    logic       err0, err1, err2;
    logic [2:0] ev0, ev1, ev2;
    logic [2:0] ee0, ee1, ee2;
`ifdef MOD5_MON_ERRCNT_EN
    logic [7:0] ec0, ec1, ec2;
`endif

    int tests;
    int failed;

    // Default configuration
    mod5_sequence_monitor dut0 (
        .clk    (clk),
        .rst    (rst),
        .In     (in0),
        .Carry  (carry0),
        .Wraps  (wraps0),
        .State  (st0),
        .Err    (err0),
        .ErrVal (ev0),
        .ErrExp (ee0)
`ifdef MOD5_MON_ERRCNT_EN
        ,
        .ErrCnt (ec0)
`endif
    );

    // Auto-resync variant
    mod5_sequence_monitor #(.WRAP_W(8), .AUTO_RESYNC(1'b1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .In     (in1),
        .Carry  (carry1),
        .Wraps  (wraps1),
        .State  (st1),
        .Err    (err1),
        .ErrVal (ev1),
        .ErrExp (ee1)
`ifdef MOD5_MON_ERRCNT_EN
        ,
        .ErrCnt (ec1)
`endif
    );

    // Narrow wrap counter variant
    mod5_sequence_monitor #(.WRAP_W(3), .AUTO_RESYNC(1'b0)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .In     (in2),
        .Carry  (carry2),
        .Wraps  (wraps2),
        .State  (st2),
        .Err    (err2),
        .ErrVal (ev2),
        .ErrExp (ee2)
`ifdef MOD5_MON_ERRCNT_EN
        ,
        .ErrCnt (ec2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] in;
        logic [1:0] st;
        logic       carry;
        logic [7:0] wraps;
        logic       err;
        logic [2:0] ev;
        logic [2:0] ee;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge and settle just past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in0 = 3'd0;
        in1 = 3'd0;
        in2 = 3'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0] mw;
        tests  = 0;
        failed = 0;
        rst    = 1'b0;
        in0    = 3'd0;
        in1    = 3'd0;
        in2    = 3'd0;

        //              in    st     c     wraps  err   ev    ee
        vecs[0]  = '{3'd0, 2'b01, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0};
        vecs[1]  = '{3'd1, 2'b01, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0};
        vecs[2]  = '{3'd2, 2'b01, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0};
        vecs[3]  = '{3'd3, 2'b01, 1'b0, 8'd0, 1'b0, 3'd0, 3'd0};
        vecs[4]  = '{3'd4, 2'b01, 1'b1, 8'd1, 1'b0, 3'd0, 3'd0};
        vecs[5]  = '{3'd0, 2'b01, 1'b0, 8'd1, 1'b0, 3'd0, 3'd0};
        vecs[6]  = '{3'd1, 2'b01, 1'b0, 8'd1, 1'b0, 3'd0, 3'd0};
        vecs[7]  = '{3'd2, 2'b01, 1'b0, 8'd1, 1'b0, 3'd0, 3'd0};
        vecs[8]  = '{3'd3, 2'b01, 1'b0, 8'd1, 1'b0, 3'd0, 3'd0};
        vecs[9]  = '{3'd4, 2'b01, 1'b1, 8'd2, 1'b0, 3'd0, 3'd0};
        vecs[10] = '{3'd0, 2'b01, 1'b0, 8'd2, 1'b0, 3'd0, 3'd0};
        vecs[11] = '{3'd1, 2'b01, 1'b0, 8'd2, 1'b0, 3'd0, 3'd0};
        vecs[12] = '{3'd2, 2'b01, 1'b0, 8'd2, 1'b0, 3'd0, 3'd0};
        // exp is now 3; skip to 4
        vecs[13] = '{3'd4, 2'b10, 1'b0, 8'd2, 1'b1, 3'd4, 3'd3};
        vecs[14] = '{3'd0, 2'b10, 1'b0, 8'd2, 1'b1, 3'd4, 3'd3};
        vecs[15] = '{3'd6, 2'b10, 1'b0, 8'd2, 1'b1, 3'd4, 3'd3};

        // Reset state
        rst = 1'b1;
        #3;
        chk("reset_outputs", {14'd0, st0, carry0, wraps0, err0, ev0, ee0}, 32'd0);
        chk("reset_dut1", {25'd0, st1, carry1, err1, ev1[0], ee1[0]}, 32'd0);
        chk("reset_dut2", {26'd0, st2, carry2, wraps2}, 32'd0);
`ifdef MOD5_MON_ERRCNT_EN
        chk("reset_errcnt", {24'd0, ec0}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Lock-step count, then a skipped step and post-fault inputs
        for (int i = 0; i < 16; i++) begin
            in0 = vecs[i].in;
            step();
            chk($sformatf("vec%0d", i),
                {14'd0, st0, carry0, wraps0, err0, ev0, ee0},
                {14'd0, vecs[i].st, vecs[i].carry, vecs[i].wraps, vecs[i].err,
                 vecs[i].ev, vecs[i].ee});
        end
`ifdef MOD5_MON_ERRCNT_EN
        chk("track_fault_errcnt", {24'd0, ec0}, 32'd1);
`endif

        // Fault in SYNC on an illegal value; 1..4 in SYNC is benign
        do_reset();
        in0 = 3'd3;
        step();
        chk("sync_benign", {29'd0, st0, err0}, {29'd0, 2'b00, 1'b0});
        in0 = 3'd6;
        step();
        chk("sync_fault", {24'd0, st0, err0, ev0, ee0}, {24'd0, 2'b10, 1'b1, 3'd6, 3'd0});
        in0 = 3'd0;
        step();
        chk("fault_hold", {22'd0, st0, wraps0}, {22'd0, 2'b10, 8'd0});

        // Auto-resync: first capture survives a second fault
        do_reset();
        in1 = 3'd0; step();
        in1 = 3'd1; step();
        in1 = 3'd5; step();
        chk("ar_fault1", {24'd0, st1, err1, ev1, ee1}, {24'd0, 2'b10, 1'b1, 3'd5, 3'd2});
        in1 = 3'd0; step();
        chk("ar_resync", {24'd0, st1, err1, ev1, ee1}, {24'd0, 2'b00, 1'b1, 3'd5, 3'd2});
        in1 = 3'd0; step();
        chk("ar_track", {30'd0, st1}, {30'd0, 2'b01});
        in1 = 3'd1; step();
        chk("ar_track2", {30'd0, st1}, {30'd0, 2'b01});
        in1 = 3'd3; step();
        chk("ar_fault2", {24'd0, st1, err1, ev1, ee1}, {24'd0, 2'b10, 1'b1, 3'd5, 3'd2});
`ifdef MOD5_MON_ERRCNT_EN
        chk("ar_errcnt", {24'd0, ec1}, 32'd2);
`endif

        // 3-bit wrap counter over 8 full cycles
        do_reset();
        mw = 3'd0;
        for (int k = 0; k < 40; k++) begin
            in2 = 3'(k % 5);
            step();
            if (in2 == 3'd4) mw = mw + 3'd1;
            chk($sformatf("w3_edge%0d", k + 1), {28'd0, carry2, wraps2},
                {28'd0, (in2 == 3'd4), mw});
        end
        chk("w3_final", {28'd0, err2, wraps2}, {28'd0, 1'b0, 3'd0});

        // Asynchronous reset while Carry is high
        do_reset();
        for (int k = 0; k < 5; k++) begin
            in0 = 3'(k);
            step();
        end
        chk("pre_rst_carry", {23'd0, carry0, wraps0}, {23'd0, 1'b1, 8'd1});
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst", {20'd0, carry0, wraps0, err0, st0}, 32'd0);
        #1;
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mod5_sequence_monitor.md
# mod5_sequence_monitor

Sequential checker that sits directly downstream of the 3-bit modulo-5 counter and consumes its `Out[2:0]` bus on the same clock. It verifies that the count follows 0→1→2→3→4→0, emits a one-cycle carry on each accepted 4→0 wrap, and accumulates a wrap count. This extends the counter's range. On any illegal value or skipped step it latches a sticky fault with diagnostic capture.

## Interface
Parameters:
- `WRAP_W`, default 8: width of the wrap counter.
- `AUTO_RESYNC`, default 0: 0 holds FAULT until reset; 1 returns to SYNC one cycle after entering FAULT.

Ports:
- `clk`  input  1  single clock; shared with the upstream counter.
- `rst`  input  1  reset; asynchronous, active-high.
- `In`  input  3  count value from the upstream counter's `Out`.
- `Carry`  output  1  one-cycle pulse per accepted wrap.
- `Wraps`  output  WRAP_W  number of accepted wraps, modulo 2^WRAP_W.
- `State`  output  2  FSM state: 00 SYNC, 01 TRACK, 10 FAULT (11 unused).
- `Err`  output  1  sticky fault flag.
- `ErrVal`  output  3  sampled `In` at the first fault.
- `ErrExp`  output  3  expected value at the first fault.
- `ErrCnt`  output  8  present only with `MOD5_MON_ERRCNT_EN`.

## Operation
- `In` is sampled on every rising `clk` edge. All outputs are registered.
- Internal register `exp[2:0]` holds the next expected value.
- Reset values: `State`=SYNC, `exp`=0, `Carry`=0, `Wraps`=0, `Err`=0, `ErrVal`=0, `ErrExp`=0, `ErrCnt`=0.
- SYNC:
  - `In`==0 → TRACK, with `exp`=1.
  - `In` in 1..4 → stay in SYNC. This is not a fault.
  - `In` in 5..7 → fault event.
- TRACK:
  - `In`==`exp` → stay in TRACK, with `exp` = (`In`==4) ? 0 : `In`+1.
  - If the accepted `In` is 4: `Carry`=1 in the following cycle, and `Wraps` += 1 at the same edge.
  - `In`≠`exp`, including values 5..7 → fault event.
- Fault event, handled at that edge:
  - `State` → FAULT and `Err` → 1.
  - If `Err` was 0: `ErrVal`=`In` and `ErrExp`=`exp`. In SYNC, `exp` is 0. Later faults do not overwrite the capture.
  - `ErrCnt` += 1, saturating at 255.
- FAULT:
  - `In` is ignored and `Wraps` is frozen.
  - With `AUTO_RESYNC`=1, the next edge moves to SYNC. The `Err`/`ErrVal`/`ErrExp` capture is retained.
  - With `AUTO_RESYNC`=0, the block stays in FAULT until `rst`.
- `Carry` is low at every edge that does not accept 4 in TRACK.
- `Wraps` wraps modulo 2^WRAP_W; 255+1 → 0 for the default width. The wrap does not affect `Carry` or `Err`.
- `exp` never takes the values 5..7.

## Timing
- Latency is 1 cycle. Every output reflects the sample taken at the previous edge.
- Upstream counter in sync lock-step:
  - Both leave reset with 0. The first post-reset edge samples 0 → TRACK.
  - `Carry` is high during the cycle in which `In`==0 after a 4.
  - A `Carry` pulse follows every 5th edge.
- Asserting `rst` mid-operation clears all state immediately, including a `Carry` that is high. Operation resumes at the first edge after `rst` deasserts.
- An `In` glitch at a single edge is a fault. No filtering is applied.
- In SYNC, the sample is evaluated for both conditions at the same edge. The fault path has priority over the TRACK-entry path; both cannot occur for one value.

## Configuration
- `MOD5_MON_ERRCNT_EN` defined:
  - The `ErrCnt[7:0]` port exists.
  - It counts fault events, saturating at 255. It is cleared only by `rst`.
  - With `AUTO_RESYNC`=1 it counts repeated faults across resyncs.
- Not defined: the `ErrCnt` port and its register are absent. All other behaviour is identical.

## Test plan
- Reset, then drive the real mod-5 counter for 12 edges. Required: `State`=01 after edge 1; `Carry` pulses after edges 5 and 10; `Wraps`=2; `Err`=0.
- In TRACK with `exp`=3, force `In`=4. Required: next cycle `State`=10, `Err`=1, `ErrVal`=4, `ErrExp`=3; with `MOD5_MON_ERRCNT_EN`, `ErrCnt`=1.
- In SYNC, drive `In`=6. Required: FAULT, `ErrVal`=6, `ErrExp`=0. Then drive `In`=0. Required with `AUTO_RESYNC`=0: stays FAULT, `Wraps` unchanged.
- `AUTO_RESYNC`=1: inject a fault, then drive 0,1,2. Required: FAULT→SYNC→TRACK; `ErrVal`/`ErrExp` hold the first capture. Inject a second fault. Required: `ErrCnt`=2, capture unchanged.
- With `WRAP_W`=3, run 8 full cycles. Required: `Wraps` goes 7→0 on the 8th accepted wrap; `Carry` still pulses; `Err`=0.
- Assert `rst` during the `Carry`=1 cycle. Required: `Carry`, `Wraps`, `Err`, `State` are 0 immediately, without waiting for a `clk` edge.
